fetch_unit: RTL and testbench

- Consumer end of the PC-generator interface: accepts the current `pc`, issues instruction-memory reads, and buffers returned {pc, instr} pairs in order for decode.
- Drives `stall` back to the PC generator whenever it cannot issue the presented `pc` this cycle.
- Sits between the PC generator, instruction memory and decode/dispatch of the Tomasulo front end.
- Top level drives `flush` = PC-generator `flush` | `branch_taken`, so every redirect empties the front end.

---
 rtl/fetch_unit.sv | 215 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Front-end fetch stage of the Tomasulo core. Takes the current fetch address
// from the PC generator and issues instruction-memory reads under a credit
// scheme. Returned words are buffered in order, as {pc, instr} pairs, for
// decode.
//
// Credit: a request is issued only when
//   - fewer than MAX_INFLIGHT requests are outstanding, and
//   - every outstanding request already owns a free queue slot.
// Because of this, an IMEM response always finds room in the queue.
//
// Flush empties the queue at once. It also arms a drop counter so that the
// responses still owed for pre-flush requests are discarded on arrival.
//
// Build option: define FETCH_BYPASS_EN to let a response arriving at an empty
// queue appear on fq_* in the same cycle. If decode takes it in that cycle,
// it is never written. Without the macro, fq_* come only from the queue
// registers, so a response is visible one cycle after it arrives.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 2,
    parameter int XLEN         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          pc,
    output logic                     stall,
    input  logic                     flush,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_resp_valid,
    input  logic [XLEN-1:0]          imem_resp_data,
    output logic                     fq_valid,
    input  logic                     fq_ready,
    output logic [XLEN-1:0]          fq_pc,
    output logic [XLEN-1:0]          fq_instr,
    output logic [$clog2(DEPTH):0]   fq_count
);

    // Queue pointer and counter widths.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Outstanding requests can never exceed DEPTH, whatever MAX_INFLIGHT is.
    // The in-flight PC FIFO therefore needs at most DEPTH entries.
    localparam int IF_DEPTH = (MAX_INFLIGHT > DEPTH) ? DEPTH : MAX_INFLIGHT;
    localparam int IW       = (IF_DEPTH > 1) ? $clog2(IF_DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] IF_DEPTH_C = CW'(IF_DEPTH);
    localparam logic [IW-1:0] IF_LAST    = IW'(IF_DEPTH - 1);

    // Fetch queue storage: PC and instruction for each entry.
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    // In-flight bookkeeping.
    // if_pc holds the PC of each outstanding request, oldest first.
    logic [XLEN-1:0] if_pc [IF_DEPTH];
    logic [IW-1:0]   if_head;
    logic [IW-1:0]   if_tail;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;

    // Per-cycle decisions.
    logic            credit_ok;
    logic            can_issue;
    logic            issue;
    logic            resp;
    logic            resp_keep;
    logic            resp_drop;
    logic [XLEN-1:0] resp_pc;
    logic            q_empty;
    logic            enq;
    logic            deq;
`ifdef FETCH_BYPASS_EN
    logic            bypass;
`endif

    // The in-flight FIFO depth need not be a power of two, so it wraps
    // explicitly.
    function automatic logic [IW-1:0] if_next(input logic [IW-1:0] p);
        return (p == IF_LAST) ? '0 : p + IW'(1);
    endfunction

    // Credit check and request issue; stall tells the PC generator to hold.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        credit_ok      = 1'b0;
        can_issue      = 1'b0;
        issue          = 1'b0;
        credit_ok      = (inflight < IF_DEPTH_C) && ((count + inflight) < DEPTH_C);
        can_issue      = !rst && !flush && credit_ok;
        issue          = can_issue && imem_req_ready;
        imem_req_valid = can_issue;
        imem_req_addr  = pc;
        stall          = !issue;
    end

    // Classify this cycle's IMEM response as kept or dropped.
    always_comb begin
        resp      = 1'b0;
        resp_keep = 1'b0;
        resp_drop = 1'b0;
        // A response with nothing outstanding belongs to a request made
        // before reset; it is ignored.
        resp      = imem_resp_valid && (inflight != '0);
        resp_drop = resp && (drop_cnt != '0);
        resp_keep = resp && (drop_cnt == '0);
        resp_pc   = if_pc[if_head];
    end

    // Queue head presentation and enqueue/dequeue decisions.
    always_comb begin
        q_empty  = (count == '0);
        deq      = fq_ready && !q_empty;
        enq      = 1'b0;
        fq_valid = 1'b0;
        fq_pc    = '0;
        fq_instr = '0;
`ifdef FETCH_BYPASS_EN
        bypass   = resp_keep && q_empty && !flush && !rst;
        enq      = resp_keep && !(bypass && fq_ready);
        fq_valid = !q_empty || bypass;
        if (!q_empty) begin
            fq_pc    = q_pc[head];
            fq_instr = q_instr[head];
        end else if (bypass) begin
            fq_pc    = resp_pc;
            fq_instr = imem_resp_data;
        end
`else
        enq      = resp_keep;
        fq_valid = !q_empty;
        if (!q_empty) begin
            fq_pc    = q_pc[head];
            fq_instr = q_instr[head];
        end
`endif
        fq_count = count;
    end

    // Control state: pointers, occupancy, credit and drop counters.
    // Flush wins over enqueue and dequeue.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so
        // every register samples pre-edge values regardless of block order.
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            if_head  <= '0;
            if_tail  <= '0;
        end else begin
            if (resp) begin
                if_head <= if_next(if_head);
            end
            if (issue) begin
                if_tail <= if_next(if_tail);
            end
            if (flush) begin
                // Nothing issues in a flush cycle.
                // Every request still owed after this cycle gets dropped.
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                inflight <= inflight - CW'(resp);
                drop_cnt <= inflight - CW'(resp);
            end else begin
                if (enq) begin
                    tail <= tail + PW'(1);
                end
                if (deq) begin
                    head <= head + PW'(1);
                end
                count    <= count + CW'(enq) - CW'(deq);
                inflight <= inflight + CW'(issue) - CW'(resp);
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    // Payload storage: queue entries and in-flight PCs.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; the pointers and counters
        // above decide which entries are meaningful.
        if (!rst && !flush && enq) begin
            q_pc[tail]    <= resp_pc;
            q_instr[tail] <= imem_resp_data;
        end
        if (issue) begin
            if_pc[if_tail] <= pc;
        end
    end

    // Invariants: the credit scheme never over-commits the queue, and the
    // drop counter never exceeds the number of requests still owed.
    a_no_overcommit: assert property (@(posedge clk) disable iff (rst)
        (count + inflight) <= DEPTH_C);
    a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
        drop_cnt <= inflight);

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. The bench provides:
//   - a small PC generator: advances pc by 4 on every issued request;
//   - an in-order IMEM: fixed latency, gateable, data = addr*32 + 0x13;
//   - a queue-level reference model.
// One compare process checks every DUT output against the model each cycle.
// Literal expectations at key points pin the model itself.
// Build with +define+FETCH_BYPASS_EN to exercise the bypass variant.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int DEPTH = 4;
    localparam int MAXI  = 2;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] pc;
    logic            stall;
    logic            flush;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            fq_valid;
    logic            fq_ready;
    logic [XLEN-1:0] fq_pc;
    logic [XLEN-1:0] fq_instr;
    logic [CW-1:0]   fq_count;

    fetch_unit #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .stall          (stall),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .fq_valid       (fq_valid),
        .fq_ready       (fq_ready),
        .fq_pc          (fq_pc),
        .fq_instr       (fq_instr),
        .fq_count       (fq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Check bookkeeping.
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a * 32 + 32'h13;
    endfunction

    // Environment state.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        imem_q[$];
    req_t        new_req;
    int          cyc      = 0;
    int          lat      = 1;
    logic        resp_en  = 1'b1;
    logic        dut_issue_s = 1'b0;
    logic [31:0] addr_s   = '0;
    int          n_issue  = 0;
    logic        cmp_en   = 1'b0;
    logic [63:0] log_q[$];
    int          log_c[$];

    // Reference model: decoded queue contents, owed request PCs, drop count.
    logic [63:0] mq[$];
    logic [31:0] mpend[$];
    int          mdrop = 0;

    function automatic logic exp_req_valid();
        return !rst && !flush && (mpend.size() < MAXI) && ((mq.size() + mpend.size()) < DEPTH);
    endfunction

    function automatic logic exp_bypass();
`ifdef FETCH_BYPASS_EN
        return !rst && !flush && (mq.size() == 0) && imem_resp_valid
               && (mpend.size() > 0) && (mdrop == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return '1;
    endfunction

    function automatic int logc_at(input int i);
        if (i < log_c.size()) return log_c[i];
        return -1;
    endfunction

    // Model update at each rising edge, from the inputs held over the cycle.
    logic        m_resp, m_iss, m_bp;
    logic [31:0] m_p;
    initial forever begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mpend.delete();
            mdrop = 0;
        end else begin
            m_resp = imem_resp_valid && (mpend.size() > 0);
            m_iss  = exp_req_valid() && imem_req_ready;
            m_bp   = exp_bypass();
            if (flush) begin
                if (m_resp) void'(mpend.pop_front());
                mdrop = mpend.size();
                mq.delete();
            end else begin
                if (fq_ready && (mq.size() > 0)) void'(mq.pop_front());
                if (m_resp) begin
                    m_p = mpend.pop_front();
                    if (mdrop > 0) mdrop--;
                    else if (!(m_bp && fq_ready)) mq.push_back({m_p, imem_resp_data});
                end
                if (m_iss) mpend.push_back(pc);
            end
        end
    end

    // In-order IMEM with configurable latency and a response gate.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                imem_q.delete();
            end else begin
                if (imem_resp_valid && (imem_q.size() > 0)) void'(imem_q.pop_front());
                if (dut_issue_s) begin
                    new_req.addr = addr_s;
                    new_req.due  = cyc + lat - 1;
                    imem_q.push_back(new_req);
                end
            end
            #2;
            if (resp_en && (imem_q.size() > 0) && (imem_q[0].due <= cyc)) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_data(imem_q[0].addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'hDEADBEEF;
            end
        end
    end

    // Compare process: mid-cycle, checks every output against the model.
    logic        c_ev, c_bp;
    logic [63:0] c_head;
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            c_ev = exp_req_valid();
            c_bp = exp_bypass();
            if (mq.size() > 0)  c_head = mq[0];
            else if (c_bp)      c_head = {mpend[0], imem_resp_data};
            else                c_head = '0;
            check("req_valid", imem_req_valid, c_ev);
            check("stall",     stall,          !(c_ev && imem_req_ready));
            check("req_addr",  imem_req_addr,  pc);
            check("fq_count",  fq_count,       mq.size());
            check("fq_valid",  fq_valid,       (mq.size() > 0) || c_bp);
            check("fq_pc",     fq_pc,          c_head[63:32]);
            check("fq_instr",  fq_instr,       c_head[31:0]);
        end
        dut_issue_s = imem_req_valid && imem_req_ready;
        addr_s      = imem_req_addr;
        if (dut_issue_s) n_issue++;
        if (fq_valid && fq_ready) begin
            log_q.push_back({fq_pc, fq_instr});
            log_c.push_back(cyc);
        end
    end

    // One cycle of the PC generator: advance after an issued request.
    task automatic cyc_step();
        @(posedge clk);
        #1;
        if (dut_issue_s) pc = pc + 32'd4;
    endtask

    int n0;

    initial begin
        rst            = 1'b1;
        pc             = '0;
        flush          = 1'b0;
        imem_req_ready = 1'b1;
        fq_ready       = 1'b1;

        // Reset.
        repeat (2) cyc_step();
        cmp_en = 1'b1;
        #2;
        check("rst_stall",     stall,          1);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_fq_valid",  fq_valid,       0);
        check("rst_fq_count",  fq_count,       0);

        // Release and stream with a 1-cycle IMEM.
        cyc_step();
        rst = 1'b0;
        pc  = 32'h0;
        log_q.delete(); log_c.delete();
        #2;
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr",  imem_req_addr,  32'h0);
        check("first_stall",     stall,          0);
        repeat (5) cyc_step();
        imem_req_ready = 1'b0;
        repeat (4) cyc_step();
        check("stream_e0", log_at(0), {32'h0, 32'h13});
        check("stream_e1", log_at(1), {32'h4, 32'h93});
        check("stream_e2", log_at(2), {32'h8, 32'h113});
        check("stream_gap01", logc_at(1) - logc_at(0), 1);
        check("stream_gap12", logc_at(2) - logc_at(1), 1);

        // Back-pressure: decode stalled, queue plus in-flight fills to DEPTH.
        cyc_step();
        fq_ready       = 1'b0;
        pc             = 32'h100;
        imem_req_ready = 1'b1;
        repeat (8) cyc_step();
        #2;
        check("bp_count",     fq_count,       4);
        check("bp_stall",     stall,          1);
        check("bp_req_valid", imem_req_valid, 0);
        check("bp_head_pc",   fq_pc,          32'h100);
        n0 = n_issue;
        cyc_step();
        fq_ready = 1'b1;
        cyc_step();
        fq_ready = 1'b0;
        repeat (5) cyc_step();
        #2;
        check("bp_one_issue",  n_issue - n0, 1);
        check("bp_count_again", fq_count,    4);
        fq_ready       = 1'b1;
        imem_req_ready = 1'b0;
        repeat (6) cyc_step();

        // IMEM not ready for three cycles at pc 0x20.
        log_q.delete(); log_c.delete();
        pc = 32'h20;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("nr_stall",     stall,          1);
            check("nr_req_valid", imem_req_valid, 1);
            cyc_step();
        end
        imem_req_ready = 1'b1;
        #2;
        check("nr_issue_stall", stall,         0);
        check("nr_issue_addr",  imem_req_addr, 32'h20);
        cyc_step();
        imem_req_ready = 1'b0;
        repeat (4) cyc_step();
        check("nr_entry", log_at(0), {32'h20, 32'h413});

        // Flush with two queued and two in flight.
        log_q.delete(); log_c.delete();
        fq_ready       = 1'b0;
        pc             = 32'h300;
        imem_req_ready = 1'b1;
        cyc_step();
        imem_req_ready = 1'b0;
        cyc_step();
        imem_req_ready = 1'b1;
        cyc_step();
        imem_req_ready = 1'b0;
        cyc_step();
        resp_en        = 1'b0;
        imem_req_ready = 1'b1;
        cyc_step();
        cyc_step();
        flush = 1'b1;
        #2;
        check("fl_pre_count", fq_count,       2);
        check("fl_stall",     stall,          1);
        check("fl_req_valid", imem_req_valid, 0);
        cyc_step();
        flush    = 1'b0;
        pc       = 32'h2000;
        resp_en  = 1'b1;
        fq_ready = 1'b1;
        #2;
        check("fl_post_count", fq_count, 0);
        check("fl_post_valid", fq_valid, 0);
        check("fl_credit_stall", stall,  1);
        repeat (5) cyc_step();
        imem_req_ready = 1'b0;
        repeat (4) cyc_step();
        check("fl_first_entry", log_at(0), {32'h2000, 32'h40013});

        // Simultaneous response and dequeue with queue + in-flight at DEPTH.
        log_q.delete(); log_c.delete();
        fq_ready = 1'b0;
        pc       = 32'h400;
        for (int i = 0; i < 3; i++) begin
            imem_req_ready = 1'b1;
            cyc_step();
            imem_req_ready = 1'b0;
            cyc_step();
        end
        resp_en        = 1'b0;
        imem_req_ready = 1'b1;
        cyc_step();
        imem_req_ready = 1'b0;
        #2;
        check("sim_pre_count",     fq_count,       3);
        check("sim_pre_req_valid", imem_req_valid, 0);
        cyc_step();
        resp_en  = 1'b1;
        fq_ready = 1'b1;
        #2;
        check("sim_cycle_count", fq_count, 3);
        cyc_step();
        fq_ready = 1'b0;
        #2;
        check("sim_after_count", fq_count, 3);
        check("sim_after_head",  fq_pc,    32'h404);
        fq_ready = 1'b1;
        repeat (5) cyc_step();
        check("sim_e0", log_at(0), {32'h400, mem_data(32'h400)});
        check("sim_e1", log_at(1), {32'h404, mem_data(32'h404)});
        check("sim_e2", log_at(2), {32'h408, mem_data(32'h408)});
        check("sim_e3", log_at(3), {32'h40C, mem_data(32'h40C)});

        // Response into an empty queue: same-cycle with bypass, else next cycle.
        fq_ready       = 1'b0;
        pc             = 32'h500;
        imem_req_ready = 1'b1;
        cyc_step();
        imem_req_ready = 1'b0;
        #2;
`ifdef FETCH_BYPASS_EN
        check("byp_valid", fq_valid, 1);
        check("byp_pc",    fq_pc,    32'h500);
        check("byp_instr", fq_instr, 32'hA013);
`else
        check("nobyp_valid", fq_valid, 0);
        check("nobyp_pc",    fq_pc,    0);
`endif
        cyc_step();
        #2;
        check("resp_next_valid", fq_valid, 1);
        check("resp_next_pc",    fq_pc,    32'h500);
        check("resp_next_instr", fq_instr, 32'hA013);
        fq_ready = 1'b1;
        repeat (3) cyc_step();

        // Reset in the middle of traffic.
        fq_ready       = 1'b0;
        pc             = 32'h600;
        imem_req_ready = 1'b1;
        repeat (3) cyc_step();
        rst = 1'b1;
        #2;
        check("mid_rst_stall",     stall,          1);
        check("mid_rst_req_valid", imem_req_valid, 0);
        cyc_step();
        #2;
        check("mid_rst_count", fq_count, 0);
        check("mid_rst_valid", fq_valid, 0);
        rst = 1'b0;
        cyc_step();
        imem_req_ready = 1'b0;
        fq_ready       = 1'b1;
        repeat (4) cyc_step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
